// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential partial-product reducer.
package mult_pkg;

  localparam int WIDTH = 64;
  localparam int ROWS  = 17;
  localparam int NPAIR = (ROWS + 1) / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } acc_state_t;

endpackage

// File: rtl/csa_4to2.sv
// Two cascaded 3:2 carry-save levels folding four operands into a sum/carry pair.
module csa_4to2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;

  // Majority shifted left; the carry out of the top bit falls off (mod 2^WIDTH).
  assign s1 = a ^ b ^ c;
  assign c1 = ((a & b) | (a & c) | (b & c)) << 1;

  assign s  = s1 ^ c1 ^ d;
  assign co = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;

endmodule

// File: rtl/pp_accumulator.sv
// Folds ROWS partial-product rows two per cycle into a carry-save pair, then
// resolves the pair with a single carry-propagate add.
module pp_accumulator #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int ROWS  = mult_pkg::ROWS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] rows_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      product,
  output logic                  busy
);
  import mult_pkg::*;

  localparam int NP = (ROWS + 1) / 2;
  localparam int IW = $clog2(NP + 1);

  acc_state_t                    state;
  logic [ROWS-1:0][WIDTH-1:0]    rows_q;
  logic [2*NP-1:0][WIDTH-1:0]    rows_pad;
  logic [WIDTH-1:0]              sum;
  logic [WIDTH-1:0]              carry;
  logic [WIDTH-1:0]              sum_nxt;
  logic [WIDTH-1:0]              carry_nxt;
  logic [IW-1:0]                 idx;
  logic [IW:0]                   sel;

  // Odd ROWS leaves the last pair half-empty; the pad row is zero.
  always_comb begin
    rows_pad = '0;
    for (int k = 0; k < ROWS; k++) rows_pad[k] = rows_q[k];
  end

  assign sel = {idx, 1'b0};

  csa_4to2 #(.WIDTH(WIDTH)) u_csa (
    .a  (sum),
    .b  (carry),
    .c  (rows_pad[sel]),
    .d  (rows_pad[sel + 1'b1]),
    .s  (sum_nxt),
    .co (carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) rows_q <= rows_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      sum       <= '0;
      carry     <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sum      <= '0;
          carry    <= '0;
          idx      <= '0;
          state    <= ACCUM;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ACCUM: begin
          sum   <= sum_nxt;
          carry <= carry_nxt;
          idx   <= idx + IW'(1);
          if (idx == IW'(NP - 1)) state <= RESOLVE;
        end
        RESOLVE: begin
          product   <= sum + carry;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
